fifo_arb: RTL and testbench

FIFO_ARB -- requirements
Module: fifo_arb

---
 rtl/fifo_arb_if.sv | 28 ++
 rtl/fifo_arb.sv | 167 ++++++++++++++++
 tb/tb_fifo_arb.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_arb_if.sv
// Bundle of the requester-side and FIFO read-side signals of fifo_arb.
// The slave modport is the arbiter's view; master is the environment's view.
interface fifo_arb_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
);
  logic [3:0]         req_i;
  logic [4*WIDTH-1:0] dat_i;
  logic [3:0]         gnt_o;
  logic [3:0]         ack_o;
  logic [WIDTH-1:0]   dat_o;
  logic [1:0]         src_o;
  logic               valid_o;
  logic               rd_i;
  logic               full_o;
  logic               empty_o;
  logic [DEPTH:0]     count_o;

  modport slave (
    input  req_i, dat_i, rd_i,
    output gnt_o, ack_o, dat_o, src_o, valid_o, full_o, empty_o, count_o
  );

  modport master (
    output req_i, dat_i, rd_i,
    input  gnt_o, ack_o, dat_o, src_o, valid_o, full_o, empty_o, count_o
  );
endinterface

// File: rtl/fifo_arb.sv
// Four-requester round-robin arbiter with bounded bursts feeding a shared FIFO
// that tags each stored word with the index of the requester that wrote it.
module fifo_arb #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int BURST = 2
) (
  input  logic       clk,
  input  logic       rst_i,
  fifo_arb_if.slave  bus
);

  localparam int                 ENTRIES    = 1 << DEPTH;
  localparam int                 CW         = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CW-1:0]      CNT_LAST   = CW'(BURST - 1);
  localparam logic [DEPTH:0]     COUNT_FULL = (DEPTH + 1)'(ENTRIES);
  localparam logic [DEPTH:0]     COUNT_ZERO = (DEPTH + 1)'(0);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             state_r, state_s;
  logic [1:0]         owner_r, owner_s;
  logic [1:0]         last_r, last_s;
  logic [CW-1:0]      cnt_r, cnt_s;
  logic [3:0]         gnt_r, gnt_s;
  logic [2:0]         pick_s;
  logic               wr_s;
  logic               rd_s;
  logic               full_s;
  logic               empty_s;
  logic [WIDTH-1:0]   owner_dat_s;
  logic [DEPTH-1:0]   wptr_r, rptr_r;
  logic [DEPTH:0]     count_r;
  logic [WIDTH+1:0]   mem_r [ENTRIES];

  // Returns {found, index}: first set request scanning last+1 .. last+4 (mod 4).
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign pick_s      = rr_pick(bus.req_i, last_r);
  assign owner_dat_s = bus.dat_i[owner_r*WIDTH +: WIDTH];
  assign full_s      = (count_r == COUNT_FULL);
  assign empty_s     = (count_r == COUNT_ZERO);
  assign rd_s        = bus.rd_i && !empty_s;

  // Arbitration state, current owner, round-robin pointer and burst counter.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      owner_r <= 2'd0;
      last_r  <= 2'd3;
      cnt_r   <= '0;
      gnt_r   <= 4'b0000;
    end else begin
      state_r <= state_s;
      owner_r <= owner_s;
      last_r  <= last_s;
      cnt_r   <= cnt_s;
      gnt_r   <= gnt_s;
    end
  end

  // Next-state logic; a write is only taken from the owner and only while not full.
  always_comb begin
    state_s = state_r;
    owner_s = owner_r;
    last_s  = last_r;
    cnt_s   = cnt_r;
    gnt_s   = gnt_r;
    wr_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_s[2]) begin
          state_s = BUSY;
          owner_s = pick_s[1:0];
          cnt_s   = '0;
          gnt_s   = 4'b0001 << pick_s[1:0];
        end else begin
          gnt_s   = 4'b0000;
        end
      end
      BUSY: begin
        if (!bus.req_i[owner_r]) begin
          state_s = IDLE;
          gnt_s   = 4'b0000;
          last_s  = owner_r;
          cnt_s   = '0;
        end else if (!full_s) begin
          wr_s = 1'b1;
          if (cnt_r == CNT_LAST) begin
            state_s = IDLE;
            gnt_s   = 4'b0000;
            last_s  = owner_r;
            cnt_s   = '0;
          end else begin
            cnt_s   = cnt_r + CW'(1);
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s = IDLE;
        gnt_s   = 4'b0000;
      end
    endcase
  end

  // Occupancy and pointers; full gating looks at the registered count only.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= COUNT_ZERO;
    end else begin
      if (wr_s) begin
        wptr_r <= wptr_r + DEPTH'(1);
      end else begin
        wptr_r <= wptr_r;
      end
      if (rd_s) begin
        rptr_r <= rptr_r + DEPTH'(1);
      end else begin
        rptr_r <= rptr_r;
      end
      case ({wr_s, rd_s})
        2'b10:   count_r <= count_r + (DEPTH + 1)'(1);
        2'b01:   count_r <= count_r - (DEPTH + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents are deliberately not reset, occupancy tracks validity.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[wptr_r] <= {owner_r, owner_dat_s};
    end else begin
      mem_r[wptr_r] <= mem_r[wptr_r];
    end
  end

  assign bus.gnt_o   = gnt_r;
  assign bus.ack_o   = wr_s ? (4'b0001 << owner_r) : 4'b0000;
  assign bus.dat_o   = mem_r[rptr_r][WIDTH-1:0];
  assign bus.src_o   = mem_r[rptr_r][WIDTH+1:WIDTH];
  assign bus.valid_o = !empty_s;
  assign bus.full_o  = full_s;
  assign bus.empty_o = empty_s;
  assign bus.count_o = count_r;

endmodule

// File: tb/tb_fifo_arb.sv
// Bench for fifo_arb: a vector table for the burst/full scenario, directed
// corner sequences, and random traffic checked against a queue-based model.
module tb_fifo_arb;

  localparam int WIDTH = 4;
  localparam int DEPTH = 2;
  localparam int BURST = 2;
  localparam int NENT  = 1 << DEPTH;

  logic clk;
  logic rst_i;
  int   errors;
  int   checks;

  fifo_arb_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  fifo_arb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BURST(BURST)) dut (
    .clk   (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queue of {src, data}, owner (-1 when idle), words taken in burst.
  logic [5:0] q_m [$];
  int         owner_m;
  int         last_m;
  int         taken_m;

  typedef struct {
    logic [3:0] req;
    logic       rd;
    logic [3:0] gnt;
    logic [3:0] ack;
    int         count;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_ref(input logic [3:0] req, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (req[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    q_m.delete();
    owner_m = -1;
    last_m  = 3;
    taken_m = 0;
  endtask

  // One cycle: drive at negedge, compare against the model, then advance the model.
  task automatic step(input logic [3:0] req, input logic [15:0] dat, input logic rd);
    logic [3:0] eg;
    logic [3:0] ea;
    logic [1:0] o2;
    int         sz;
    @(negedge clk);
    bus.req_i = req;
    bus.dat_i = dat;
    bus.rd_i  = rd;
    #1;
    sz = q_m.size();
    eg = (owner_m < 0) ? 4'b0000 : (4'b0001 << owner_m);
    ea = 4'b0000;
    if (owner_m >= 0 && req[owner_m] && sz < NENT) ea = 4'b0001 << owner_m;
    chk("gnt", int'(bus.gnt_o), int'(eg));
    chk("ack", int'(bus.ack_o), int'(ea));
    chk("count", int'(bus.count_o), sz);
    chk("valid", int'(bus.valid_o), int'(sz > 0));
    chk("empty", int'(bus.empty_o), int'(sz == 0));
    chk("full", int'(bus.full_o), int'(sz == NENT));
    if (sz > 0) begin
      chk("dat", int'(bus.dat_o), int'(q_m[0][3:0]));
      chk("src", int'(bus.src_o), int'(q_m[0][5:4]));
    end
    if (rd && sz > 0) void'(q_m.pop_front());
    if (ea != 4'b0000) begin
      o2 = 2'(owner_m);
      q_m.push_back({o2, dat[owner_m*4 +: 4]});
    end
    if (owner_m < 0) begin
      owner_m = rr_ref(req, last_m);
      taken_m = 0;
    end else if (!req[owner_m]) begin
      last_m  = owner_m;
      owner_m = -1;
    end else if (ea != 4'b0000) begin
      taken_m++;
      if (taken_m == BURST) begin
        last_m  = owner_m;
        owner_m = -1;
      end
    end
  endtask

  // Asserts reset away from any clock edge and checks the outputs react at once.
  task automatic reset_async();
    #2;
    rst_i = 1'b1;
    #1;
    chk("rst_gnt", int'(bus.gnt_o), 0);
    chk("rst_ack", int'(bus.ack_o), 0);
    chk("rst_count", int'(bus.count_o), 0);
    chk("rst_empty", int'(bus.empty_o), 1);
    chk("rst_full", int'(bus.full_o), 0);
    chk("rst_valid", int'(bus.valid_o), 0);
    model_reset();
    bus.req_i = 4'b0000;
    bus.rd_i  = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  initial begin
    logic [3:0]  rq;
    logic [31:0] m;
    errors    = 0;
    checks    = 0;
    rst_i     = 1'b1;
    bus.req_i = 4'b0000;
    bus.dat_i = 16'h0000;
    bus.rd_i  = 1'b0;
    model_reset();

    //            req      rd    gnt      ack      count
    tbl[0]  = '{4'b1111, 1'b0, 4'b0000, 4'b0000, 0};
    tbl[1]  = '{4'b1111, 1'b0, 4'b0001, 4'b0001, 0};
    tbl[2]  = '{4'b1111, 1'b0, 4'b0001, 4'b0001, 1};
    tbl[3]  = '{4'b1111, 1'b0, 4'b0000, 4'b0000, 2};
    tbl[4]  = '{4'b1111, 1'b0, 4'b0010, 4'b0010, 2};
    tbl[5]  = '{4'b1111, 1'b0, 4'b0010, 4'b0010, 3};
    tbl[6]  = '{4'b1111, 1'b0, 4'b0000, 4'b0000, 4};
    tbl[7]  = '{4'b1111, 1'b0, 4'b0100, 4'b0000, 4};
    tbl[8]  = '{4'b1111, 1'b0, 4'b0100, 4'b0000, 4};
    tbl[9]  = '{4'b1111, 1'b1, 4'b0100, 4'b0000, 4};
    tbl[10] = '{4'b1111, 1'b0, 4'b0100, 4'b0100, 3};
    tbl[11] = '{4'b1111, 1'b0, 4'b0100, 4'b0000, 4};

    #1;
    chk("rst0_gnt", int'(bus.gnt_o), 0);
    chk("rst0_empty", int'(bus.empty_o), 1);
    chk("rst0_count", int'(bus.count_o), 0);
    @(negedge clk);
    rst_i = 1'b0;

    // Burst of two per requester, full stall, and pop-then-refill while full.
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].req, 16'hDCBA, tbl[i].rd);
      chk($sformatf("tbl%0d_gnt", i), int'(bus.gnt_o), int'(tbl[i].gnt));
      chk($sformatf("tbl%0d_ack", i), int'(bus.ack_o), int'(tbl[i].ack));
      chk($sformatf("tbl%0d_count", i), int'(bus.count_o), tbl[i].count);
    end

    // Single word from requester 2, then drop; next arbitration favours requester 0.
    reset_async();
    step(4'b0100, 16'h0500, 1'b0);
    step(4'b0100, 16'h0500, 1'b0);
    step(4'b0000, 16'h0000, 1'b0);
    chk("drop_src", int'(bus.src_o), 2);
    chk("drop_dat", int'(bus.dat_o), 5);
    step(4'b0101, 16'h0000, 1'b0);
    step(4'b0101, 16'h0000, 1'b0);
    chk("drop_next_gnt", int'(bus.gnt_o), 1);

    // Requester 1 streaming while the reader drains every cycle.
    reset_async();
    for (int i = 0; i < 12; i++) begin
      step(4'b0010, 16'($urandom), 1'b1);
      chk("stream_cnt_le1", int'(bus.count_o <= 1), 1);
    end

    // Six words with interleaved pops so both pointers wrap, then drain.
    reset_async();
    for (int i = 0; i < 9; i++) step(4'b1000, 16'($urandom), 1'(i % 2));
    for (int i = 0; i < 8; i++) step(4'b0000, 16'h0000, 1'b1);
    chk("wrap_empty", int'(bus.empty_o), 1);

    // Reset while busy with three words stored.
    reset_async();
    for (int i = 0; i < 6; i++) step(4'b0010, 16'h00F0, 1'b0);
    chk("midbusy_count", int'(bus.count_o), 3);
    chk("midbusy_gnt", int'(bus.gnt_o), 2);
    reset_async();
    step(4'b0000, 16'h0000, 1'b0);

    // Random sticky requests with two read-pressure phases.
    rq = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      m  = $urandom & $urandom;
      rq = rq ^ m[3:0];
      step(rq, 16'($urandom), (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
